// File: rtl/slab_interval_sched_pkg.sv
// Shared definitions for the slab interval scheduler: float field encodings,
// default word geometry, FSM state encoding and step-index width.
package slab_interval_sched_pkg;

    localparam int unsigned WE_DEF = 11;
    localparam int unsigned WF_DEF = 6;
    localparam int unsigned W_DEF  = WE_DEF + WF_DEF + 3;

    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    localparam logic [W_DEF-1:0] FP_ZERO = '0;

    localparam int unsigned         STEP_W    = 3;
    localparam logic [STEP_W-1:0]   STEP_LAST = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    function automatic logic is_nan(input logic [1:0] exn);
        return exn == EXN_NAN;
    endfunction

endpackage

// File: rtl/slab_wait_cnt.sv
// Loadable down-counter that flags the final cycle of a fixed-latency wait,
// for schedulers that own a pipelined FP unit with constant latency.
module slab_wait_cnt #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/slab_interval_sched.sv
// Finishes the ray/AABB slab test for one box by sequencing six max/min/order
// comparisons through a single shared external FP less-or-equal comparator.
module slab_interval_sched
    import slab_interval_sched_pkg::*;
#(
    parameter int unsigned WE      = WE_DEF,
    parameter int unsigned WF      = WF_DEF,
    parameter int unsigned CMP_LAT = 3,
    localparam int unsigned W      = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] tnear_x_i,
    input  logic [W-1:0] tnear_y_i,
    input  logic [W-1:0] tnear_z_i,
    input  logic [W-1:0] tfar_x_i,
    input  logic [W-1:0] tfar_y_i,
    input  logic [W-1:0] tfar_z_i,
    output logic [W-1:0] cmp_a_o,
    output logic [W-1:0] cmp_b_o,
    input  logic         cmp_le_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         hit_o,
    output logic [W-1:0] t_enter_o,
    output logic [W-1:0] t_exit_o
);

    localparam int unsigned CW = 4;

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [W-1:0]        nx_q, ny_q, nz_q, fx_q, fy_q, fz_q;
    logic [W-1:0]        mx_q, mn_q, t_enter_q, t_exit_q;
    logic [W-1:0]        cmp_a_q, cmp_b_q;
    logic [W-1:0]        op_a, op_b;
    logic                nan_q, c_ord_q, hit_q, out_valid_q;
    logic                in_nan, cnt_last;

    assign in_nan = is_nan(tnear_x_i[W-1:W-2]) | is_nan(tnear_y_i[W-1:W-2])
                  | is_nan(tnear_z_i[W-1:W-2]) | is_nan(tfar_x_i[W-1:W-2])
                  | is_nan(tfar_y_i[W-1:W-2])  | is_nan(tfar_z_i[W-1:W-2]);

    // Operand pair presented to the comparator for each step.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (step_q)
            3'd0: begin op_a = nx_q;        op_b = ny_q;     end
            3'd1: begin op_a = mx_q;        op_b = nz_q;     end
            3'd2: begin op_a = fx_q;        op_b = fy_q;     end
            3'd3: begin op_a = mn_q;        op_b = fz_q;     end
            3'd4: begin op_a = t_enter_q;   op_b = t_exit_q; end
            3'd5: begin op_a = W'(FP_ZERO); op_b = t_exit_q; end
            default: ;
        endcase
    end

    slab_wait_cnt #(
        .CW (CW)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == StIssue),
        .load_val_i (CW'(CMP_LAT)),
        .dec_i      (state_q == StWait),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            nz_q        <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            fz_q        <= '0;
            mx_q        <= '0;
            mn_q        <= '0;
            t_enter_q   <= '0;
            t_exit_q    <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            nan_q       <= 1'b0;
            c_ord_q     <= 1'b0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        nx_q    <= tnear_x_i;
                        ny_q    <= tnear_y_i;
                        nz_q    <= tnear_z_i;
                        fx_q    <= tfar_x_i;
                        fy_q    <= tfar_y_i;
                        fz_q    <= tfar_z_i;
                        nan_q   <= in_nan;
                        step_q  <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cmp_a_q <= op_a;
                    cmp_b_q <= op_b;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_last) begin
                        // Ties: max keeps operand B, min keeps operand A.
                        case (step_q)
                            3'd0: mx_q      <= cmp_le_i ? ny_q : nx_q;
                            3'd1: t_enter_q <= cmp_le_i ? nz_q : mx_q;
                            3'd2: mn_q      <= cmp_le_i ? fx_q : fy_q;
                            3'd3: t_exit_q  <= cmp_le_i ? mn_q : fz_q;
                            3'd4: c_ord_q   <= cmp_le_i;
                            3'd5: hit_q     <= c_ord_q & cmp_le_i & ~nan_q;
                            default: ;
                        endcase
                        if (step_q == STEP_LAST) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            step_q  <= step_q + STEP_W'(1);
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign cmp_a_o     = cmp_a_q;
    assign cmp_b_o     = cmp_b_q;
    assign out_valid_o = out_valid_q;
    assign hit_o       = hit_q;
    assign t_enter_o   = t_enter_q;
    assign t_exit_o    = t_exit_q;

endmodule
